ddr2_line_responder: RTL

- Memory-side end of the cache's 128-bit line interface: accepts line read and line write requests from the cache and services them in order against a block-RAM line store.
- Models DDR2 timing with a fixed service latency.
- Stands in for the DDR2 controller in simulation, and in FPGA builds that have no DDR2.
- Reads return a full 128-bit line with a one-cycle ddr2_available pulse. Writes are silent: the cache issues a write-back immediately followed by a refill read and does not wait for a write acknowledgement.

---
 rtl/ddr2_line_if.sv | 15 +
 rtl/ddr2_line_responder.sv | 79 +++++++
 2 files changed

// File: rtl/ddr2_line_if.sv
// ddr2_line_if: cache-to-memory 128-bit line request/response bundle
interface ddr2_line_if;
    logic         ddr2_enable;
    logic         ddr2_read;
    logic [26:0]  ddr2_addr;
    logic [127:0] to_ddr2_data;
    logic         ddr2_available;
    logic [127:0] ddr2_data;
    logic         busy;
    logic         overflow;
    modport master (output ddr2_enable, ddr2_read, ddr2_addr, to_ddr2_data,
                    input ddr2_available, ddr2_data, busy, overflow);
    modport slave  (input ddr2_enable, ddr2_read, ddr2_addr, to_ddr2_data,
                    output ddr2_available, ddr2_data, busy, overflow);
endinterface

// File: rtl/ddr2_line_responder.sv
// ddr2_line_responder: in-order fixed-latency line read/write server over a block-RAM store
module ddr2_line_responder #(
    parameter int LINE_AW = 10,
    parameter int LATENCY = 8,
    parameter int QDEPTH  = 4
) (
    input logic clk,
    input logic rst_n,
    ddr2_line_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic [PW:0] fcnt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic f_read [QDEPTH];
    logic [LINE_AW-1:0] f_idx [QDEPTH];
    logic [127:0] f_data [QDEPTH];
    logic cur_read;
    logic [LINE_AW-1:0] cur_idx;
    logic [127:0] cur_data;
    logic [127:0] store [2**LINE_AW];
    logic [LINE_AW-1:0] in_idx;
    logic empty, full, done, pop, bypass, push, drop, load;
    logic unused_addr;
    assign unused_addr = ^{bus.ddr2_addr[26:LINE_AW+4], bus.ddr2_addr[3:0]};
    always_comb begin
        in_idx   = bus.ddr2_addr[LINE_AW+3:4];
        empty    = fcnt == '0;
        full     = fcnt == (PW+1)'(QDEPTH);
        done     = state == SERVE && cnt == 8'd0;
        pop      = !empty && (state == IDLE || done);
        bypass   = state == IDLE && empty && bus.ddr2_enable;
        push     = bus.ddr2_enable && !bypass && (!full || pop);
        drop     = bus.ddr2_enable && !bypass && full && !pop;
        load     = pop || bypass;
        state_nx = load ? SERVE : done ? IDLE : state;
    end
    assign bus.busy = state != IDLE || !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            fcnt               <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            cur_read           <= 1'b0;
            cur_idx            <= '0;
            cur_data           <= '0;
            bus.ddr2_available <= 1'b0;
            bus.ddr2_data      <= '0;
            bus.overflow       <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= load ? 8'(LATENCY - 1) : (state == SERVE && !done) ? cnt - 8'd1 : cnt;
            fcnt   <= fcnt + (PW+1)'(push) - (PW+1)'(pop);
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            if (load) begin
                cur_read <= bypass ? bus.ddr2_read : f_read[rd_ptr];
                cur_idx  <= bypass ? in_idx : f_idx[rd_ptr];
                cur_data <= bypass ? bus.to_ddr2_data : f_data[rd_ptr];
            end
            bus.ddr2_available <= done && cur_read;
            if (done && cur_read) bus.ddr2_data <= store[cur_idx];
            if (drop) bus.overflow <= 1'b1;
        end
    end
    // Queue slots and the line store carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            f_read[wr_ptr] <= bus.ddr2_read;
            f_idx[wr_ptr]  <= in_idx;
            f_data[wr_ptr] <= bus.to_ddr2_data;
        end
        if (done && !cur_read) store[cur_idx] <= cur_data;
    end
endmodule
